serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a - b - borrow_in, LSB first, one bit per clock.
- Uses a single full-subtractor cell (diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin)) plus a borrow flip-flop.
- Inverse-direction companion to the team's 1-bit full adder (inp1/inp2/carryin -> sum/carryout); serves area-constrained datapaths and cross-checks serial add results.
- start/busy/done handshake with a serial tap for streaming consumers.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  minuend, captured on accepted start.
b  input  WIDTH  subtrahend, captured on accepted start.
borrow_in  input  1  initial borrow, captured on accepted start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse, result valid.
diff  output  WIDTH  a - b - borrow_in mod 2^WIDTH; held until next accepted start.
borrow_out  output  1  final borrow (1 when unsigned a < b + borrow_in).
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
diff_bit  output  1  current serial result bit.
diff_bit_valid  output  1  high in the cycle diff_bit is valid.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy, done, diff, borrow_out, ovf, diff_bit, diff_bit_valid all 0; internal shift registers, bit counter and borrow flop cleared. Takes effect immediately regardless of clk.
- Reset mid-operation aborts the operation. No done pulse. After release the block is IDLE and accepts start on the first edge.
- States:
  - IDLE: start=1 at edge k captures a, b, borrow_in; bit counter=0; goes to SHIFT; busy=1 and done=0 after edge k.
  - SHIFT: at each of edges k+1..k+WIDTH, process bit i=counter. Registered result bit i=a[i]^b[i]^bflop. Update bflop to the new borrow. diff_bit=that bit, diff_bit_valid=1, counter increments.
  - At edge k+WIDTH (i=WIDTH-1), drive diff/borrow_out/ovf from completed values, return to IDLE, busy=0, done=1.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. exactly WIDTH clocks after the start edge. Throughput is one operation per WIDTH+1 cycles minimum; start may be asserted in the done cycle and is accepted.
- diff/borrow_out/ovf update only at completion. During SHIFT they hold the previous result; they are not partial values.
- done is 1 for exactly one cycle. diff_bit_valid is 1 for exactly WIDTH consecutive cycles per operation, bits in LSB-to-MSB order. diff_bit holds its last value when invalid.
- start while busy=1 is ignored; captured operands are unaffected. a/b/borrow_in changes after capture have no effect.
- Counter width is clog2(WIDTH). Completion is detected on counter==WIDTH-1 with no wrap past WIDTH.
- Identities: a=b with borrow_in=0 gives diff=0, borrow_out=0. a=0, b=0, borrow_in=1 gives diff=all ones, borrow_out=1.

Test Plan:
1. WIDTH=8; a=0x05, b=0x03, borrow_in=0, start at edge k -> done high exactly at cycle k+8; diff=0x02, borrow_out=0, ovf=0; diff_bit sequence LSB first 0,1,0,0,0,0,0,0 with diff_bit_valid high 8 cycles.
2. a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, ovf=0. Then a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
3. Signed overflow: a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow_out=0. a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow_out=1.
4. Start pulsed again 3 cycles into an operation with different operands -> ignored; first result unchanged, single done pulse. Start asserted in the done cycle -> accepted, next done 8 cycles later.
5. rst_n asserted asynchronously (between edges) at bit 4 -> all outputs 0 immediately, no done. After release, a=0x10, b=0x01 -> diff=0x0F after 8 cycles.
6. Randomized 1000 operations compared against a - b - borrow_in reference model. Also check diff/borrow_out/ovf remain stable during SHIFT.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b - borrow_in,
// LSB first, one bit per clock, using a single full-subtractor cell and a
// borrow flip-flop. start/busy/done handshake plus a per-bit serial tap.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf,
   output logic             diff_bit,
   output logic             diff_bit_valid
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_nxt;
   logic [CW-1:0]    cnt;
   logic             bflop;
   logic             a_msb;
   logic             b_msb;

   logic             accept;
   logic             last_bit;
   logic             x;
   logic             y;
   logic             d;
   logic             nb;

   // The single full-subtractor cell operating on the current operand LSBs.
   assign x        = a_sh[0];
   assign y        = b_sh[0];
   assign d        = x ^ y ^ bflop;
   assign nb       = (~x & y) | (~(x ^ y) & bflop);
   assign res_nxt  = {d, res_sh[WIDTH-1:1]};

   assign accept   = (state == IDLE) && start;
   assign last_bit = (state == SHIFT) && (cnt == LAST);
   assign busy     = (state == SHIFT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is always written with non-blocking assignments
      // so every flop samples pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: IDLE -> SHIFT on accepted start, back after the MSB.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Datapath: capture operands, shift one bit per cycle, publish result at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every datapath register is reset (not just control) so an aborted
      // operation leaves no stale operands, borrow or outputs behind.
      if (!rst_n) begin
         a_sh           <= '0;
         b_sh           <= '0;
         res_sh         <= '0;
         cnt            <= '0;
         bflop          <= 1'b0;
         a_msb          <= 1'b0;
         b_msb          <= 1'b0;
         done           <= 1'b0;
         diff           <= '0;
         borrow_out     <= 1'b0;
         ovf            <= 1'b0;
         diff_bit       <= 1'b0;
         diff_bit_valid <= 1'b0;
      end else begin
         done           <= 1'b0;
         diff_bit_valid <= 1'b0;
         if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            bflop <= borrow_in;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
         end else if (state == SHIFT) begin
            a_sh           <= a_sh >> 1;
            b_sh           <= b_sh >> 1;
            res_sh         <= res_nxt;
            bflop          <= nb;
            diff_bit       <= d;
            diff_bit_valid <= 1'b1;
            if (last_bit) begin
               // Counter stops at WIDTH-1; it is reloaded on the next start.
               diff       <= res_nxt;
               borrow_out <= nb;
               ovf        <= (a_msb != b_msb) && (d != a_msb);
               done       <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// (WIDTH=8): handshake timing, serial tap order, result flags, ignored starts,
// back-to-back operation and asynchronous abort.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         borrow_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         ovf;
   logic         diff_bit;
   logic         diff_bit_valid;

   int tests = 0;
   int fails = 0;

   // Previously published result, expected to hold during SHIFT.
   logic [W-1:0] prev_diff = '0;
   logic         prev_bo   = 1'b0;
   logic         prev_ovf  = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .a              (a),
      .b              (b),
      .borrow_in      (borrow_in),
      .busy           (busy),
      .done           (done),
      .diff           (diff),
      .borrow_out     (borrow_out),
      .ovf            (ovf),
      .diff_bit       (diff_bit),
      .diff_bit_valid (diff_bit_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"},  32'(busy), 0);
      check({tag, ".done"},  32'(done), 0);
      check({tag, ".diff"},  32'(diff), 0);
      check({tag, ".bo"},    32'(borrow_out), 0);
      check({tag, ".ovf"},   32'(ovf), 0);
      check({tag, ".dbit"},  32'(diff_bit), 0);
      check({tag, ".dval"},  32'(diff_bit_valid), 0);
   endtask

   // Called at a negedge. Starts an operation, then follows nbits serial bits.
   // With nbits==W it also checks completion; returns at the done negedge.
   // inject_at >= 0 pulses start with other operands at that bit.
   task automatic do_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input logic [W-1:0] ediff, input logic ebo,
                        input logic eovf, input int nbits, input int inject_at);
      a = va; b = vb; borrow_in = vbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".busy_after_start"}, 32'(busy), 1);
      check({tag, ".done_after_start"}, 32'(done), 0);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == inject_at) begin
            a = ~va; b = va ^ vb; borrow_in = ~vbin; start = 1'b1;
         end
         check($sformatf("%s.dval[%0d]", tag, i), 32'(diff_bit_valid), 1);
         check($sformatf("%s.dbit[%0d]", tag, i), 32'(diff_bit), 32'(ediff[i]));
         if (i < W - 1) begin
            check($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 1);
            check($sformatf("%s.done_early[%0d]", tag, i), 32'(done), 0);
            check($sformatf("%s.diff_hold[%0d]", tag, i), 32'(diff), 32'(prev_diff));
            check($sformatf("%s.bo_hold[%0d]", tag, i), 32'(borrow_out), 32'(prev_bo));
            check($sformatf("%s.ovf_hold[%0d]", tag, i), 32'(ovf), 32'(prev_ovf));
         end else begin
            check({tag, ".done"}, 32'(done), 1);
            check({tag, ".busy_end"}, 32'(busy), 0);
            check({tag, ".diff"}, 32'(diff), 32'(ediff));
            check({tag, ".borrow_out"}, 32'(borrow_out), 32'(ebo));
            check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
            prev_diff = ediff; prev_bo = ebo; prev_ovf = eovf;
         end
      end
      start = 1'b0;
   endtask

   // One cycle after done: pulse gone, tap invalid but holding the MSB.
   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, ".done_single"}, 32'(done), 0);
      check({tag, ".dval_off"}, 32'(diff_bit_valid), 0);
      check({tag, ".busy_idle"}, 32'(busy), 0);
      check({tag, ".dbit_hold"}, 32'(diff_bit), 32'(prev_diff[W-1]));
      check({tag, ".diff_keep"}, 32'(diff), 32'(prev_diff));
   endtask

   initial begin
      logic [W-1:0] ra, rb, md;
      logic         rbin, mbo, movf;
      logic [W:0]   full;

      // Reset state.
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic subtraction, timing and serial order.
      do_op("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, W, -1);
      idle_check("t1");

      // 2: underflow and all-ones identity; a=b identity.
      do_op("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, W, -1);
      idle_check("t2a");
      do_op("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, W, -1);
      idle_check("t2b");
      do_op("t2c", 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, W, -1);
      idle_check("t2c");

      // 3: signed overflow cases.
      do_op("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, W, -1);
      idle_check("t3a");
      do_op("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, W, -1);
      idle_check("t3b");

      // 4: start while busy is ignored; start in the done cycle is accepted.
      do_op("t4a", 8'h5A, 8'h21, 1'b1, 8'h38, 1'b0, 1'b0, W, 2);
      do_op("t4b", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, W, -1);
      idle_check("t4b");

      // 5: asynchronous reset while bit 4 is on the tap.
      do_op("t5a", 8'hC3, 8'h42, 1'b0, 8'h81, 1'b0, 1'b0, 5, -1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("t5_async");
      repeat (2) @(posedge clk);
      #1 check_all_zero("t5_held");
      @(negedge clk);
      rst_n = 1'b1;
      prev_diff = '0; prev_bo = 1'b0; prev_ovf = 1'b0;
      @(negedge clk);
      check("t5.no_done", 32'(done), 0);
      do_op("t5b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, W, -1);
      idle_check("t5b");

      // 6: randomized operations against an arithmetic reference model.
      for (int n = 0; n < 1000; n++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rbin = 1'($urandom);
         full = {1'b0, ra} - {1'b0, rb} - (W+1)'(rbin);
         md   = full[W-1:0];
         mbo  = full[W];
         movf = (ra[W-1] != rb[W-1]) && (md[W-1] != ra[W-1]);
         do_op($sformatf("rnd%0d", n), ra, rb, rbin, md, mbo, movf, W, -1);
         if (n % 7 == 0) idle_check($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time limit so a stuck design cannot hang the run.
   initial begin
      #2_000_000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1, "timeout");
   end

endmodule
